// File: rtl/note_pkg.sv
// Shared encodings for the note history block: op codes and match-counter FSM states.
package note_pkg;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_READ  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_COUNT = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/note_match_counter.sv
// Counts recorded entries equal to a key. Sequential one-comparator scan by default;
// single-cycle compare-and-sum when NOTE_HISTORY_FAST_COUNT_EN is defined.
module note_match_counter
    import note_pkg::*;
#(
    parameter int NOTE_W = 3,
    parameter int DEPTH  = 128,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NOTE_W-1:0]         key,
    input  logic [DEPTH*NOTE_W-1:0]   entries,
    input  logic [CNT_W-1:0]          fill,
    output logic [CNT_W-1:0]          count,
    output logic                      busy,
    output logic                      done
);

    logic [NOTE_W-1:0] entry [DEPTH];

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry[i] = entries[i*NOTE_W +: NOTE_W];
        end
    end

`ifdef NOTE_HISTORY_FAST_COUNT_EN

    logic [CNT_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < fill && entry[i] == key) begin
                sum = sum + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                count <= sum;
            end
        end
    end

    assign busy = 1'b0;

`else

    scan_state_e       state_q, state_d;
    logic [CNT_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_d;
    logic              done_d;
    logic [NOTE_W-1:0] key_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            acc_q <= '0;
            count <= '0;
            done  <= 1'b0;
            key_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            acc_q <= acc_d;
            count <= count_d;
            done  <= done_d;
            if (start) begin
                key_q <= key;
            end
        end
    end

    // ptr only indexes storage while ptr < fill <= DEPTH, so the low IDX_W bits suffice
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        acc_d   = acc_q;
        count_d = count;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    ptr_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_SCAN: begin
                if (ptr_q < fill) begin
                    if (entry[ptr_q[IDX_W-1:0]] == key_q) begin
                        acc_d = acc_q + CNT_W'(1);
                    end
                    ptr_d = ptr_q + CNT_W'(1);
                end else begin
                    count_d = acc_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_SCAN);

`endif

endmodule

// File: rtl/note_history.sv
// Note history buffer: shift-register storage, fill counter, indexed READ, CLEAR and COUNT.
// Optional single-cycle COUNT via NOTE_HISTORY_FAST_COUNT_EN.
module note_history
    import note_pkg::*;
#(
    parameter int NOTE_W = 3,
    parameter int DEPTH  = 128,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [1:0]        op,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [NOTE_W-1:0] key,
    output logic [NOTE_W-1:0] note_out,
    output logic              rd_err,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  fill,
    output logic              busy,
    output logic              done
);

    logic [NOTE_W-1:0]       mem [DEPTH];
    logic [DEPTH*NOTE_W-1:0] entries;
    op_e                     op_sel;
    logic                    accept;
    logic                    start;

    assign op_sel = op_e'(op);
    assign accept = op_valid && !busy;
    assign start  = accept && (op_sel == OP_COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            fill     <= '0;
            note_out <= '0;
            rd_err   <= 1'b0;
        end else if (accept) begin
            case (op_sel)
                OP_PUSH: begin
                    mem[0] <= note_in;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        mem[i] <= mem[i-1];
                    end
                    if (fill != CNT_W'(DEPTH)) begin
                        fill <= fill + CNT_W'(1);
                    end
                end
                OP_READ: begin
                    if (CNT_W'(rd_idx) < fill) begin
                        note_out <= mem[rd_idx];
                        rd_err   <= 1'b0;
                    end else begin
                        note_out <= '0;
                        rd_err   <= 1'b1;
                    end
                end
                OP_CLEAR: begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                    fill <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        entries = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i*NOTE_W +: NOTE_W] = mem[i];
        end
    end

    note_match_counter #(
        .NOTE_W (NOTE_W),
        .DEPTH  (DEPTH)
    ) u_match (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .key     (key),
        .entries (entries),
        .fill    (fill),
        .count   (count),
        .busy    (busy),
        .done    (done)
    );

endmodule

// File: doc/note_history.md
# note_history

Parametrised note history buffer with indexed readback and match counting. Successor to the fixed 128×3-bit recorder: configurable note width and depth, a fill counter, a CLEAR op, and a start/busy/done handshake for COUNT. The COUNT scan covers only recorded entries, so empty slots never match. Sits between the note decoder and the playback/statistics logic, on the system clock.

## Interface
- NOTE_W, 3, bits per note
- DEPTH, 128, number of stored notes; must be ≥ 2
- IDX_W (localparam), $clog2(DEPTH), index width
- CNT_W (localparam), $clog2(DEPTH+1), count/fill width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- op_valid  in  1  op strobe; an op is taken on an edge with op_valid=1 and busy=0
- op  in  2  00 PUSH, 01 READ, 10 CLEAR, 11 COUNT
- note_in  in  NOTE_W  note for PUSH
- rd_idx  in  IDX_W  READ index; 0 = most recent note
- key  in  NOTE_W  note value COUNT searches for
- note_out  out  NOTE_W  READ result, registered; reset 0
- rd_err  out  1  high while last READ index ≥ fill; reset 0
- count  out  CNT_W  last COUNT result, held; reset 0
- fill  out  CNT_W  entries recorded, saturates at DEPTH; reset 0
- busy  out  1  COUNT scan in progress; reset 0
- done  out  1  one-cycle pulse when count updates; reset 0

## Operation
- Storage: DEPTH×NOTE_W shift register, entry 0 newest. Reset and CLEAR zero all entries and fill.
- PUSH: entries shift toward DEPTH-1 and note_in enters entry 0. The oldest entry is discarded when full. fill increments, saturating at DEPTH.
- READ: if rd_idx < fill, note_out ← entry[rd_idx] and rd_err ← 0. Otherwise note_out ← 0 and rd_err ← 1. count is unchanged.
- CLEAR: storage and fill ← 0. note_out, count and rd_err are unchanged.
- COUNT: snapshot key. Scan entries 0..fill-1 and count entries equal to key. Result goes to count together with a done pulse.
- While busy=1, op_valid is ignored, so no op can change storage mid-scan. Upstream must hold or drop ops.
- Scan FSM, states IDLE and SCAN:
  - IDLE→SCAN on an accepted COUNT: ptr ← 0, acc ← 0.
  - In SCAN, each edge with ptr < fill: acc += (entry[ptr]==key), then ptr++.
  - When ptr == fill: count ← acc, done ← 1, return to IDLE.
- All arithmetic is unsigned. acc ≤ fill ≤ DEPTH, so CNT_W bits cannot overflow.

## Timing
- PUSH, READ and CLEAR take effect on the accepting edge. Their results are visible the following cycle.
- Sequential COUNT accepted at edge k:
  - busy is high after edges k … k+fill.
  - count and done are updated at edge k+fill+1.
  - fill=0 gives done one cycle after accept with count=0.
- done is high for exactly one cycle. busy falls on the same edge that done rises.
- Back-to-back COUNT is allowed on the first cycle with busy=0.
- Reset asserted mid-scan: FSM→IDLE, busy=0 and done=0 immediately. No late done pulse follows.

## Configuration
- NOTE_HISTORY_FAST_COUNT_EN defined: COUNT is a single-cycle combinational compare-and-sum over all valid entries. count and done update at the accepting edge, busy stays 0 permanently, and the SCAN state is not built.
- Undefined (default): sequential scan as above. One comparator, with latency fill+1 cycles.

## Structure
- Package note_pkg holds:
  - op encodings OP_PUSH, OP_READ, OP_CLEAR, OP_COUNT
  - FSM state enum ST_IDLE/ST_SCAN
- Sub-module note_match_counter owns the scan FSM (ptr, acc, busy, done) or the combinational sum under the macro. The top holds storage, fill and READ.

## Test plan
- Reset, 5 PUSHes (1,2,3,4,5), READ idx 0 → note_out=5; READ idx 4 → 1; READ idx 5 → note_out=0, rd_err=1; fill=5.
- 130 PUSHes of i%8 (DEPTH=128) → fill=128. READ idx 127 → 2, since the two oldest notes were dropped.
- Store 3,0,3,7 then COUNT key=3 → busy for 5 cycles, then done pulse with count=2. COUNT key=0 → 1, proving empty slots are not counted. With FAST_COUNT_EN → done 1 cycle after accept.
- PUSH with op_valid during busy → ignored: fill and count unchanged and the scan result is correct.
- CLEAR then COUNT key=0 → count=0, done 1 cycle after accept. READ idx 0 → rd_err=1.
- Assert reset asynchronously mid-scan → busy, done, fill and count are 0 before the next clk edge, and no done pulse appears afterwards.
